// File: rtl/decode_realign_pkg.sv
// Shared decode types: parse-state encoding and the RVC halfword classifier.
// Used by decode_realign and decode_realign_leftover.
package decode_types;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_SKIP  = 2'd3
  } parse_state_t;

  localparam int HW_W   = 16;
  localparam int WORD_W = 32;

  function automatic logic is_rvc(input logic [HW_W-1:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/decode_realign_leftover.sv
// Holds the upper halfword of a fetch word that starts a 32-bit instruction
// whose second half lives in the next fetch word.
module decode_realign_leftover
  import decode_types::*;
#(
  parameter int ALEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_set,
  input  logic [HW_W-1:0] i_hw,
  input  logic [ALEN-1:0] i_addr,
  output logic            o_valid,
  output logic [HW_W-1:0] o_hw,
  output logic [ALEN-1:0] o_addr
);

  logic            r_valid;
  logic [HW_W-1:0] r_hw;
  logic [ALEN-1:0] r_addr;

  // Clear wins over set so a flush never leaves a stale halfword behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_hw    <= '0;
      r_addr  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_hw    <= i_hw;
      r_addr  <= i_addr;
    end
  end

  assign o_valid = r_valid;
  assign o_hw    = r_hw;
  assign o_addr  = r_addr;

endmodule

// File: rtl/decode_realign.sv
// Fetch-word to instruction realigner. With CORE_RVC_EN defined it splits words into
// 16/32-bit instructions; without it every word passes through whole.
module decode_realign
  import decode_types::*;
#(
  parameter int ALEN = 32,
  parameter int ILEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ALEN-1:0]   redirect_addr,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [WORD_W-1:0] fetch_data,
  input  logic [ALEN-1:0]   fetch_addr,
  input  logic              fetch_exception,
  input  logic [3:0]        fetch_trap_cause,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ILEN-1:0]   instruction,
  output logic [ALEN-1:0]   instruction_addr,
  output logic [ALEN-1:0]   instruction_next_addr,
  output logic              ifetch_exception,
  output logic [3:0]        ifetch_trap_cause
);

  logic              r_out_valid;
  logic [ILEN-1:0]   r_instr;
  logic [ALEN-1:0]   r_iaddr;
  logic [ALEN-1:0]   r_inext;
  logic              r_oexc;
  logic [3:0]        r_ocause;

  logic              w_out_free;
  logic              w_accept;
  logic              w_emit;
  logic [WORD_W-1:0] w_instr;
  logic [ALEN-1:0]   w_iaddr;
  logic [ALEN-1:0]   w_inext;
  logic              w_exc;
  logic [3:0]        w_cause;

  logic              w_lo_set;
  logic              w_lo_clr;
  logic [HW_W-1:0]   w_lo_hw_in;
  logic [ALEN-1:0]   w_lo_addr_in;
  logic              w_lo_valid;
  logic [HW_W-1:0]   w_lo_hw;
  logic [ALEN-1:0]   w_lo_addr;
  logic              w_unused;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_accept   = fetch_valid && fetch_ready && !flush;

  decode_realign_leftover #(
    .ALEN (ALEN)
  ) u_leftover (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush || w_lo_clr),
    .i_set   (w_lo_set && !flush),
    .i_hw    (w_lo_hw_in),
    .i_addr  (w_lo_addr_in),
    .o_valid (w_lo_valid),
    .o_hw    (w_lo_hw),
    .o_addr  (w_lo_addr)
  );

`ifdef CORE_RVC_EN
  parse_state_t      r_state;
  logic [WORD_W-1:0] r_word;
  logic [ALEN-1:0]   r_addr;

  logic [WORD_W-1:0] w_src_word;
  logic [ALEN-1:0]   w_src_addr;
  logic [ALEN-1:0]   w_hi_addr;
  logic [ALEN-1:0]   w_parse_addr;
  logic              w_at_high;
  logic              w_go;
  parse_state_t      w_next_state;

  assign fetch_ready = ((r_state == S_EMPTY) || (r_state == S_SKIP)) && w_out_free;

  // A newly accepted word is parsed in its acceptance cycle; a held word only resumes at halfword 1.
  always_comb begin
    w_src_word   = w_accept ? fetch_data : r_word;
    w_src_addr   = w_accept ? fetch_addr : r_addr;
    w_hi_addr    = w_src_addr + ALEN'(2);
    w_at_high    = w_accept ? (r_state == S_SKIP) : 1'b1;
    w_parse_addr = w_at_high ? w_hi_addr : w_src_addr;
    w_go         = w_accept || ((r_state == S_HIGH) && w_out_free);
    w_emit       = 1'b0;
    w_instr      = 32'h0000_0000;
    w_iaddr      = w_src_addr;
    w_inext      = w_src_addr + ALEN'(4);
    w_exc        = 1'b0;
    w_cause      = 4'h0;
    w_lo_set     = 1'b0;
    w_lo_clr     = 1'b0;
    w_lo_hw_in   = w_src_word[31:16];
    w_lo_addr_in = w_hi_addr;
    w_next_state = r_state;
    if (w_go) begin
      if (w_accept && fetch_exception) begin
        w_emit       = 1'b1;
        w_exc        = 1'b1;
        w_cause      = fetch_trap_cause;
        w_iaddr      = w_lo_valid ? w_lo_addr : w_parse_addr;
        w_inext      = w_iaddr + ALEN'(4);
        w_lo_clr     = 1'b1;
        w_next_state = S_EMPTY;
      end else if (w_lo_valid && !w_at_high) begin
        w_emit       = 1'b1;
        w_instr      = {w_src_word[15:0], w_lo_hw};
        w_iaddr      = w_lo_addr;
        w_inext      = w_lo_addr + ALEN'(4);
        w_lo_clr     = 1'b1;
        w_next_state = S_HIGH;
      end else if (!w_at_high) begin
        w_emit = 1'b1;
        if (is_rvc(w_src_word[15:0])) begin
          w_instr      = {16'h0000, w_src_word[15:0]};
          w_inext      = w_src_addr + ALEN'(2);
          w_next_state = S_HIGH;
        end else begin
          w_instr      = w_src_word;
          w_next_state = S_EMPTY;
        end
      end else begin
        w_next_state = S_EMPTY;
        if (is_rvc(w_src_word[31:16])) begin
          w_emit  = 1'b1;
          w_instr = {16'h0000, w_src_word[31:16]};
          w_iaddr = w_hi_addr;
          w_inext = w_hi_addr + ALEN'(2);
        end else begin
          w_lo_set = 1'b1;
        end
      end
    end else begin
      w_next_state = r_state;
    end
  end

  // Parse position and held word; a redirect to an odd halfword skips halfword 0 of the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_word  <= '0;
      r_addr  <= '0;
    end else if (flush) begin
      r_state <= redirect_addr[1] ? S_SKIP : S_EMPTY;
    end else begin
      if (w_go) begin
        r_state <= w_next_state;
      end
      if (w_accept) begin
        r_word <= fetch_data;
        r_addr <= fetch_addr;
      end
    end
  end

  assign w_unused = ^{redirect_addr[ALEN-1:2], redirect_addr[0]};
`else
  assign fetch_ready = w_out_free;

  // Whole-word pass-through; non-11 low bits are left for the decoder to reject.
  always_comb begin
    w_emit       = w_accept;
    w_instr      = fetch_data;
    w_iaddr      = fetch_addr;
    w_inext      = fetch_addr + ALEN'(4);
    w_exc        = fetch_exception;
    w_cause      = fetch_exception ? fetch_trap_cause : 4'h0;
    w_lo_set     = 1'b0;
    w_lo_clr     = 1'b1;
    w_lo_hw_in   = '0;
    w_lo_addr_in = '0;
  end

  assign w_unused = ^{redirect_addr, w_lo_valid, w_lo_hw, w_lo_addr};
`endif

  // Output slot: loads only when free, so a stalled entry stays stable until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_iaddr     <= '0;
      r_inext     <= '0;
      r_oexc      <= 1'b0;
      r_ocause    <= 4'h0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_oexc      <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_instr     <= ILEN'(w_instr);
      r_iaddr     <= w_iaddr;
      r_inext     <= w_inext;
      r_oexc      <= w_exc;
      r_ocause    <= w_cause;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid             = r_out_valid;
  assign instruction           = r_instr;
  assign instruction_addr      = r_iaddr;
  assign instruction_next_addr = r_inext;
  assign ifetch_exception      = r_oexc;
  assign ifetch_trap_cause     = r_ocause;

endmodule

// File: tb/tb_decode_realign.sv
// Table-driven bench with an output scoreboard for decode_realign; expectations
// follow CORE_RVC_EN when it is defined for the build.
module tb_decode_realign;

`ifdef CORE_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] redirect_addr;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_addr;
  logic        fetch_exception;
  logic [3:0]  fetch_trap_cause;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_next_addr;
  logic        ifetch_exception;
  logic [3:0]  ifetch_trap_cause;

  decode_realign #(.ALEN(32), .ILEN(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .redirect_addr         (redirect_addr),
    .fetch_valid           (fetch_valid),
    .fetch_ready           (fetch_ready),
    .fetch_data            (fetch_data),
    .fetch_addr            (fetch_addr),
    .fetch_exception       (fetch_exception),
    .fetch_trap_cause      (fetch_trap_cause),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .instruction           (instruction),
    .instruction_addr      (instruction_addr),
    .instruction_next_addr (instruction_next_addr),
    .ifetch_exception      (ifetch_exception),
    .ifetch_trap_cause     (ifetch_trap_cause)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] next;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  typedef struct packed {
    logic [31:0]      word;
    logic [31:0]      addr;
    logic             exc;
    logic [3:0]       cause;
    logic [1:0]       n;
    logic [1:0][31:0] ei;
    logic [1:0][31:0] ea;
    logic [1:0][31:0] en;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   out_idx  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [31:0] w, input logic [31:0] a, input logic e,
                               input logic [3:0] c, input logic [1:0] n,
                               input logic [31:0] i0, input logic [31:0] a0, input logic [31:0] n0,
                               input logic [31:0] i1, input logic [31:0] a1, input logic [31:0] n1);
    vec_t v;
    v.word = w; v.addr = a; v.exc = e; v.cause = c; v.n = n;
    v.ei[0] = i0; v.ea[0] = a0; v.en[0] = n0;
    v.ei[1] = i1; v.ea[1] = a1; v.en[1] = n1;
    return v;
  endfunction

  task automatic push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] n,
                      input logic e, input logic [3:0] c);
    exp_t x;
    x.instr = i; x.addr = a; x.next = n; x.exc = e; x.cause = c;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] a, input logic e, input logic [3:0] c);
    int n;
    n = 0;
    @(posedge clk); #1;
    fetch_valid = 1'b1; fetch_data = d; fetch_addr = a; fetch_exception = e; fetch_trap_cause = c;
    @(negedge clk);
    while (!fetch_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout addr=%h got fetch_ready=0 want 1", a);
    end
    @(posedge clk); #1;
    fetch_valid = 1'b0; fetch_exception = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL idle_%s got pending=%0d out_valid=%b want pending=0 out_valid=0", name, sb.size(), out_valid);
      sb.delete();
    end
  endtask

  // Scoreboard: compare each transferred entry against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got instr=%h addr=%h want no output", instruction, instruction_addr);
      end else begin
        e = sb.pop_front();
        if (e.exc)
          ok = (ifetch_exception === 1'b1) && (ifetch_trap_cause === e.cause) && (instruction_addr === e.addr);
        else
          ok = (ifetch_exception === 1'b0) && (instruction === e.instr) &&
               (instruction_addr === e.addr) && (instruction_next_addr === e.next);
        if (!ok) begin
          failures++;
          $display("FAIL out[%0d] got instr=%h addr=%h next=%h exc=%b cause=%h want instr=%h addr=%h next=%h exc=%b cause=%h",
                   out_idx, instruction, instruction_addr, instruction_next_addr, ifetch_exception,
                   ifetch_trap_cause, e.instr, e.addr, e.next, e.exc, e.cause);
        end
      end
      out_idx++;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; redirect_addr = 32'h0; fetch_valid = 1'b0; fetch_data = 32'h0;
    fetch_addr = 32'h0; fetch_exception = 1'b0; fetch_trap_cause = 4'h0; out_ready = 1'b1;

`ifdef CORE_RVC_EN
    tbl.push_back(mkv(32'h45054501, 32'h1000, 1'b0, 4'h0, 2'd2, 32'h4501, 32'h1000, 32'h1002, 32'h4505, 32'h1002, 32'h1004));
    tbl.push_back(mkv(32'h05134501, 32'h2000, 1'b0, 4'h0, 2'd1, 32'h4501, 32'h2000, 32'h2002, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h45010000, 32'h2004, 1'b0, 4'h0, 2'd2, 32'h0513, 32'h2002, 32'h2006, 32'h4501, 32'h2006, 32'h2008));
    tbl.push_back(mkv(32'h00A00513, 32'h5000, 1'b0, 4'h0, 2'd1, 32'h00A00513, 32'h5000, 32'h5004, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h00000513, 32'hFFFFFFFC, 1'b0, 4'h0, 2'd1, 32'h0513, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h05134501, 32'h2000, 1'b0, 4'h0, 2'd1, 32'h4501, 32'h2000, 32'h2002, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'hDEADBEEF, 32'h2004, 1'b1, 4'h1, 2'd1, 32'h0, 32'h2002, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h45054501, 32'h4000, 1'b0, 4'h0, 2'd2, 32'h4501, 32'h4000, 32'h4002, 32'h4505, 32'h4002, 32'h4004));
    tbl.push_back(mkv(32'h12345678, 32'h8000, 1'b1, 4'h5, 2'd1, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h45010513, 32'h9000, 1'b0, 4'h0, 2'd1, 32'h45010513, 32'h9000, 32'h9004, 32'h0, 32'h0, 32'h0));
`else
    tbl.push_back(mkv(32'h45054501, 32'h1000, 1'b0, 4'h0, 2'd1, 32'h45054501, 32'h1000, 32'h1004, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h05134501, 32'h2000, 1'b0, 4'h0, 2'd1, 32'h05134501, 32'h2000, 32'h2004, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h45010000, 32'h2004, 1'b0, 4'h0, 2'd1, 32'h45010000, 32'h2004, 32'h2008, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h00A00513, 32'h5000, 1'b0, 4'h0, 2'd1, 32'h00A00513, 32'h5000, 32'h5004, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h00000513, 32'hFFFFFFFC, 1'b0, 4'h0, 2'd1, 32'h0513, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'hDEADBEEF, 32'h2004, 1'b1, 4'h1, 2'd1, 32'h0, 32'h2004, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h12345678, 32'h8000, 1'b1, 4'h5, 2'd1, 32'h0, 32'h8000, 32'h0, 32'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(32'h45010513, 32'h9000, 1'b0, 4'h0, 2'd1, 32'h45010513, 32'h9000, 32'h9004, 32'h0, 32'h0, 32'h0));
`endif

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_exc", 32'(ifetch_exception), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);
    chk("rst_out_valid_rel", 32'(out_valid), 32'h0);

    foreach (tbl[i]) begin
      for (int k = 0; k < int'(tbl[i].n); k++)
        push(tbl[i].ei[k], tbl[i].ea[k], tbl[i].en[k], tbl[i].exc, tbl[i].cause);
      send(tbl[i].word, tbl[i].addr, tbl[i].exc, tbl[i].cause);
    end
    wait_idle("table");

    // fetch_ready drops for exactly one cycle while the second halfword is pending.
    if (RVC) begin
      push(32'h4501, 32'h1000, 32'h1002, 1'b0, 4'h0);
      push(32'h4505, 32'h1002, 32'h1004, 1'b0, 4'h0);
    end else begin
      push(32'h45054501, 32'h1000, 32'h1004, 1'b0, 4'h0);
    end
    send(32'h45054501, 32'h1000, 1'b0, 4'h0);
    @(negedge clk);
    chk("ready_after_accept", 32'(fetch_ready), RVC ? 32'h0 : 32'h1);
    @(negedge clk);
    chk("ready_second_cycle", 32'(fetch_ready), 32'h1);
    wait_idle("ready");

    // Back-pressure: outputs hold for three cycles, then drain without loss.
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (RVC) begin
      push(32'h4501, 32'h6000, 32'h6002, 1'b0, 4'h0);
      push(32'h4505, 32'h6002, 32'h6004, 1'b0, 4'h0);
    end else begin
      push(32'h45054501, 32'h6000, 32'h6004, 1'b0, 4'h0);
    end
    send(32'h45054501, 32'h6000, 1'b0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_instr", instruction, RVC ? 32'h00004501 : 32'h45054501);
      chk("stall_addr", instruction_addr, 32'h6000);
      chk("stall_fetch_ready", 32'(fetch_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("stall");

    // Flush discards a stalled entry; odd redirect skips halfword 0 of the next word.
    out_ready = 1'b0;
    send(32'h45054501, 32'h7000, 1'b0, 4'h0);
    @(posedge clk); #1;
    flush = 1'b1; redirect_addr = 32'h3002;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    if (RVC) push(32'h4505, 32'h3002, 32'h3004, 1'b0, 4'h0);
    else     push(32'h4505FFFF, 32'h3000, 32'h3004, 1'b0, 4'h0);
    send(32'h4505FFFF, 32'h3000, 1'b0, 4'h0);
    wait_idle("flush");

    // Asynchronous reset mid-operation drops the held leftover and a stalled entry.
    if (RVC) push(32'h4501, 32'h2000, 32'h2002, 1'b0, 4'h0);
    else     push(32'h05134501, 32'h2000, 32'h2004, 1'b0, 4'h0);
    send(32'h05134501, 32'h2000, 1'b0, 4'h0);
    wait_idle("pre_reset");
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h45054501, 32'hA000, 1'b0, 4'h0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_ready", 32'(fetch_ready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    if (RVC) begin
      push(32'h4501, 32'h1000, 32'h1002, 1'b0, 4'h0);
      push(32'h4505, 32'h1002, 32'h1004, 1'b0, 4'h0);
    end else begin
      push(32'h45054501, 32'h1000, 32'h1004, 1'b0, 4'h0);
    end
    send(32'h45054501, 32'h1000, 1'b0, 4'h0);
    wait_idle("post_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
